// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: frame-based serial pattern scanner.
// Each frame of 1..16 words is loaded one word at a time and shifted MSB
// first into a pattern detector. Every occurrence, overlapping ones and
// ones that span words, pulses match_pulse and bumps a saturating counter.
// Optional build macro: PATTERN_PROG_EN adds a programmable 4-bit pattern
// port. Without it the detector looks for a fixed 1101.
module pattern_scan_ctrl #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        frame_len,
`ifdef PATTERN_PROG_EN
   input  logic [3:0]        pattern,
`endif
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              busy,
   output logic              match_pulse,
   output logic [CNT_W-1:0]  match_cnt,
   output logic              done
);

   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t            state, state_nxt;
   logic [4:0]        words_left;
   logic [BW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic              in_bit;
   logic              frame_start;
   logic              accept;
   logic              shift_en;
   logic              hit;

   assign in_bit      = shreg[DATA_W-1];
   assign frame_start = (state == IDLE) && start;
   assign accept      = (state == LOAD) && in_valid;
   assign shift_en    = (state == SHIFT);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and status outputs
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = LOAD;
         end
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (bit_cnt == '0) state_nxt = (words_left == 5'd1) ? DONE : LOAD;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Word/bit counters, shift register, registered match pulse and counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         words_left  <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         match_pulse <= 1'b0;
         match_cnt   <= '0;
      end else begin
         match_pulse <= 1'b0;
         if (frame_start) begin
            words_left <= (frame_len == 4'd0) ? 5'd16 : {1'b0, frame_len};
            match_cnt  <= '0;
         end
         if (accept) begin
            shreg   <= in_data;
            bit_cnt <= BW'(DATA_W - 1);
         end
         if (shift_en) begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt - 1'b1;
            if (bit_cnt == '0) words_left <= words_left - 1'b1;
            if (hit) begin
               match_pulse <= 1'b1;
               if (match_cnt != '1) match_cnt <= match_cnt + 1'b1;
            end
         end
      end
   end

`ifdef PATTERN_PROG_EN
   logic [3:0] pat_q;
   logic [2:0] hist;
   logic [1:0] hist_n;

   // A match needs three earlier bits of this frame plus the incoming bit
   assign hit = shift_en && (hist_n == 2'd3) && ({hist, in_bit} == pat_q);

   // Pattern latch and 3-bit history with saturating fill count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat_q  <= '0;
         hist   <= '0;
         hist_n <= '0;
      end else if (frame_start) begin
         pat_q  <= pattern;
         hist   <= '0;
         hist_n <= '0;
      end else if (shift_en) begin
         hist <= {hist[1:0], in_bit};
         if (hist_n != 2'd3) hist_n <= hist_n + 2'd1;
      end
   end
`else
   typedef enum logic [2:0] {D_NONE, D_1, D_11, D_110, D_1101} det_t;

   det_t det, det_nxt;

   // Pulse on entering the accept state; counting on the transition keeps
   // a stalled LOAD sitting in D_1101 from re-triggering.
   assign hit = shift_en && (det_nxt == D_1101);

   // Overlapping 1101 detector transitions
   always_comb begin
      det_nxt = D_NONE;
      case (det)
         D_NONE: det_nxt = in_bit ? D_1    : D_NONE;
         D_1:    det_nxt = in_bit ? D_11   : D_NONE;
         D_11:   det_nxt = in_bit ? D_11   : D_110;
         D_110:  det_nxt = in_bit ? D_1101 : D_NONE;
         D_1101: det_nxt = in_bit ? D_11   : D_NONE;
         default: det_nxt = D_NONE;
      endcase
   end

   // Detector state advances only while shifting; cleared per frame
   always_ff @(posedge clk or posedge reset) begin
      if (reset)            det <= D_NONE;
      else if (frame_start) det <= D_NONE;
      else if (shift_en)    det <= det_nxt;
   end
`endif

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Testbench for pattern_scan_ctrl (DATA_W=8, CNT_W=4). Builds the expected
// per-cycle output trace of every frame from the frame's bit stream and
// stall plan, and compares it against the DUT on every falling edge.
module tb_pattern_scan_ctrl;

   logic       clk = 1'b0;
   logic       reset, start, in_valid;
   logic [3:0] frame_len;
   logic [7:0] in_data;
   logic       in_ready, busy, match_pulse, done;
   logic [3:0] match_cnt;
   logic [3:0] pat_q;
`ifdef PATTERN_PROG_EN
   logic [3:0] pattern;
`endif

   pattern_scan_ctrl #(.DATA_W(8), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
`ifdef PATTERN_PROG_EN
      .pattern(pattern),
`endif
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .busy(busy), .match_pulse(match_pulse), .match_cnt(match_cnt), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic       busy;
      logic       ready;
      logic       done;
      logic       pulse;
      logic [3:0] cnt;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         pulse_cyc[$];
   int         done_cnt_q[$];
   int         done_cyc_q[$];
   logic [7:0] fr_words[16];
   int         fr_stall[16];
   int         model_cnt;
   int         hold_cnt;
   int         start_cyc;

   function automatic exp_t mk(input logic b, input logic r, input logic d,
                               input logic p, input int c);
      exp_t e;
      e.busy  = b;
      e.ready = r;
      e.done  = d;
      e.pulse = p;
      e.cnt   = (c > 15) ? 4'd15 : 4'(c);
      return e;
   endfunction

   // Per-cycle comparison against the expected trace
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done) begin
            done_cnt_q.push_back(int'(match_cnt));
            done_cyc_q.push_back(cyc);
         end
         if (match_pulse) pulse_cyc.push_back(cyc);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({busy, in_ready, done, match_pulse, match_cnt} !== e) begin
               errors++;
               $display("FAIL trace cyc %0d: got busy=%0b rdy=%0b done=%0b pulse=%0b cnt=%0d, required %0b %0b %0b %0b %0d",
                        cyc, busy, in_ready, done, match_pulse, match_cnt,
                        e.busy, e.ready, e.done, e.pulse, e.cnt);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         tick();
         start    = 1'b0;
         in_valid = 1'($urandom);
         in_data  = 8'($urandom);
         exp_q.push_back(mk(0, 0, 0, 0, hold_cnt));
      end
   endtask

   task automatic do_abort();
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      hold_cnt = 0;
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      tick();
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      repeat (3) begin
         tick();
         reset    = 1'b0;
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         exp_q.push_back(mk(0, 0, 0, 0, 0));
      end
      tick();
      in_valid = 1'b0;
      exp_q.push_back(mk(0, 0, 0, 0, 0));
   endtask

   // Drive one frame and predict its trace; abort_at>0 asserts reset in
   // that frame cycle (1 = first cycle after the start edge).
   task automatic run_frame(input int n, input int abort_at);
      logic       hist[$];
      int         cnt;
      logic       pend;
      int         fcyc;
      logic       b;
      logic [3:0] w4;
      tick();
      start     = 1'b1;
      frame_len = 4'(n);
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
`ifdef PATTERN_PROG_EN
      pattern   = pat_q;
`endif
      start_cyc = cyc;
      exp_q.push_back(mk(0, 0, 0, 0, hold_cnt));
      cnt  = 0;
      pend = 1'b0;
      fcyc = 0;
      for (int k = 0; k < n; k++) begin
         for (int s = 0; s <= fr_stall[k]; s++) begin
            tick();
            fcyc++;
            if (fcyc == abort_at) begin do_abort(); return; end
            start    = 1'($urandom);
            in_valid = (s == fr_stall[k]);
            in_data  = (s == fr_stall[k]) ? fr_words[k] : 8'($urandom);
            exp_q.push_back(mk(1, 1, 0, pend, cnt));
            pend = 1'b0;
         end
         for (int j = 7; j >= 0; j--) begin
            tick();
            fcyc++;
            if (fcyc == abort_at) begin do_abort(); return; end
            start    = 1'($urandom);
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            exp_q.push_back(mk(1, 0, 0, pend, cnt));
            b = fr_words[k][j];
            hist.push_back(b);
            pend = 1'b0;
            if (hist.size() >= 4) begin
               w4 = {hist[hist.size()-4], hist[hist.size()-3],
                     hist[hist.size()-2], hist[hist.size()-1]};
               pend = (w4 == pat_q);
            end
            if (pend) cnt++;
         end
      end
      tick();
      start    = 1'($urandom);
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      exp_q.push_back(mk(1, 0, 1, pend, cnt));
      model_cnt = cnt;
      hold_cnt  = (cnt > 15) ? 15 : cnt;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      exp_q.push_back(mk(0, 0, 0, 0, hold_cnt));
   endtask

   function automatic int last_done_cnt();
      return (done_cnt_q.size() > 0) ? done_cnt_q[done_cnt_q.size()-1] : -1;
   endfunction

   function automatic int latency();
      return (done_cyc_q.size() > 0) ? done_cyc_q[done_cyc_q.size()-1] - start_cyc + 1 : -1;
   endfunction

   task automatic frame_pulses(output int np, output int p0, output int p1);
      np = 0;
      p0 = -1;
      p1 = -1;
      foreach (pulse_cyc[i]) begin
         if (pulse_cyc[i] >= start_cyc) begin
            if (np == 0) p0 = pulse_cyc[i] - start_cyc;
            if (np == 1) p1 = pulse_cyc[i] - start_cyc;
            np++;
         end
      end
   endtask

   initial begin
      int np, p0, p1, n;
      reset     = 1'b1;
      start     = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hFF;
      frame_len = 4'd1;
      pat_q     = 4'b1101;
`ifdef PATTERN_PROG_EN
      pattern   = 4'b1101;
`endif
      hold_cnt  = 0;
      for (int i = 0; i < 16; i++) fr_stall[i] = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", int'({in_ready, busy, match_pulse, done, match_cnt}), 0);
      tick();
      reset    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      idle(2);

      // Single word 0xD0: one match after the fourth shift
      fr_words[0] = 8'hD0;
      run_frame(1, 0);
      frame_pulses(np, p0, p1);
      chk("d0_model_cnt", model_cnt, 1);
      chk("d0_done_cnt", last_done_cnt(), 1);
      chk("d0_latency", latency(), 11);
      chk("d0_pulses", np, 1);
      chk("d0_pulse_pos", p0, 6);
      idle(2);

      // Single word 0xDB: two overlapping matches three cycles apart
      fr_words[0] = 8'hDB;
      run_frame(1, 0);
      frame_pulses(np, p0, p1);
      chk("db_model_cnt", model_cnt, 2);
      chk("db_done_cnt", last_done_cnt(), 2);
      chk("db_pulses", np, 2);
      chk("db_spacing", p1 - p0, 3);
      idle(1);

      // Cross-word match with a 5-cycle LOAD stall
      fr_words[0] = 8'h01;
      fr_words[1] = 8'hA0;
      fr_stall[1] = 5;
      run_frame(2, 0);
      chk("xword_model_cnt", model_cnt, 1);
      chk("xword_done_cnt", last_done_cnt(), 1);
      chk("xword_latency", latency(), 2 * 9 + 2 + 5);
      fr_stall[1] = 0;
      idle(3);

      // frame_len=0 -> 16 words of 0xDB, counter saturates
      for (int i = 0; i < 16; i++) fr_words[i] = 8'hDB;
      run_frame(16, 0);
      chk("sat_model_cnt", model_cnt, 32);
      chk("sat_done_cnt", last_done_cnt(), 15);
      chk("sat_latency", latency(), 16 * 9 + 2);
      idle(2);

      // Reset during SHIFT of the second word, then a fresh frame
      run_frame(2, 13);
      fr_words[0] = 8'hD0;
      run_frame(1, 0);
      chk("post_reset_cnt", last_done_cnt(), 1);
      idle(1);

`ifdef PATTERN_PROG_EN
      pat_q       = 4'b0110;
      fr_words[0] = 8'h66;
      run_frame(1, 0);
      chk("prog_model_cnt", model_cnt, 2);
      chk("prog_done_cnt", last_done_cnt(), 2);
      pat_q = 4'b1101;
      idle(1);
`endif

      // Randomized frames
      for (int f = 0; f < 40; f++) begin
         n = int'($urandom_range(1, 16));
         for (int i = 0; i < 16; i++) begin
            fr_words[i] = 8'($urandom);
            fr_stall[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         end
`ifdef PATTERN_PROG_EN
         pat_q = 4'($urandom);
`endif
         if (f == 20) run_frame(n, int'($urandom_range(1, 9 * n)));
         else         run_frame(n, 0);
         idle(int'($urandom_range(0, 3)));
      end

      idle(2);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8: bits per input word, shifted MSB first.
REQ-002 SHALL have parameter CNT_W, default 8: width of match_cnt.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-005 SHALL have port start  in  1: begin a frame; sampled only in IDLE.
REQ-006 SHALL have port frame_len  in  4: words per frame, sampled with start; 0 means 16.
REQ-007 SHALL have port in_valid  in  1: in_data valid.
REQ-008 SHALL have port in_data  in  DATA_W: input word.
REQ-009 SHALL have port in_ready  out  1: word accepted when in_valid and in_ready are both high.
REQ-010 SHALL have port busy  out  1: high in every state except IDLE.
REQ-011 SHALL have port match_pulse  out  1: high for one cycle per detected pattern occurrence.
REQ-012 SHALL have port match_cnt  out  CNT_W: matches in current/last frame.
REQ-013 SHALL have port done  out  1: one-cycle pulse at frame end.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE.
REQ-015 IDLE: start=1 SHALL latch frame_len, clear match_cnt, clear detector history, and move to LOAD; start outside IDLE SHALL be ignored.
REQ-016 LOAD: in_ready=1; on handshake SHALL capture in_data into the shift register and move to SHIFT; without in_valid SHALL stay in LOAD with detector state held.
REQ-017 SHIFT: one bit per cycle, MSB first, for exactly DATA_W cycles; in_ready=0.
REQ-018 After the last bit of a word, SHALL go to LOAD if words remain, else to DONE.
REQ-019 DONE: done=1 for exactly one cycle, then IDLE.
REQ-020 Detector history SHALL persist across word boundaries and LOAD stalls within one frame; patterns spanning words count.
REQ-021 Overlapping occurrences SHALL be counted: in 1101101, the pattern 1101 occurs twice.
REQ-022 match_pulse SHALL be registered: high in the cycle after the clock edge that shifts in the pattern's final bit.
REQ-023 match_cnt SHALL increment on the same edge that raises match_pulse, and SHALL saturate at 2^CNT_W-1.
REQ-024 A match completed by the final bit of a frame SHALL coincide with the DONE cycle and SHALL be included in match_cnt at done.
REQ-025 match_cnt SHALL hold its value from DONE until the next accepted start.
REQ-026 Frame latency, with no stalls, SHALL be N*(DATA_W+1)+2 cycles from start to done; the +2 covers the IDLE->LOAD and DONE transitions.

Reset
REQ-027 While reset=1, SHALL immediately force: state=IDLE, in_ready=0, busy=0, match_pulse=0, done=0, match_cnt=0, detector history cleared, word counter=0.
REQ-028 Reset mid-frame SHALL abandon the frame; after reset the block SHALL accept no words until a new start.

Configuration
REQ-029 Macro PATTERN_PROG_EN defined: SHALL add input port pattern[3:0], sampled with start. Matching is then a compare of the last 4 shifted bits, oldest bit in pattern[3]. No match is possible before 4 bits are shifted in the frame.
REQ-030 Macro PATTERN_PROG_EN undefined: SHALL have no pattern port and SHALL detect fixed 1101 using a 5-state Moore detector. Counts and timing SHALL be identical to the enabled case with pattern=4'b1101.

Verification
REQ-031 frame_len=1, in_data=8'hD0 -> match_pulse 1 cycle after 4th shift edge; done with match_cnt=1.
REQ-032 frame_len=1, in_data=8'hDB -> two match_pulses, 3 cycles apart; match_cnt=2 at done.
REQ-033 frame_len=2, words 8'h01, 8'hA0, in_valid low 5 cycles between words -> one cross-word match; match_cnt=1; in_ready high throughout stall.
REQ-034 CNT_W=4, frame_len=0, 16 words of 8'hDB -> match_cnt saturates at 15; done after 16 words.
REQ-035 Reset asserted during SHIFT of 2nd word -> all outputs 0 immediately. A new start with frame_len=1, 8'hD0 -> match_cnt=1.
REQ-036 PATTERN_PROG_EN defined, pattern=4'b0110, frame_len=1, 8'h66 -> match_cnt=2.
